multicycle_control: RTL and testbench

Multicycle MIPS control unit that replaces the single-cycle opcode decoder. An explicit state machine sequences fetch, decode, execute, memory and write-back over several cycles, and drives the shared-memory datapath mux and write-enable signals. It adds the following over the single-cycle decoder:
- a wait-state handshake with unified instruction/data memory;
- bne, j, ori and slti support;
- a bus timeout;
- illegal-opcode fault detection;
- a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 76 +++++++
 rtl/multicycle_control_classify.sv | 35 +++
 rtl/multicycle_control.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multicycle MIPS control unit.
//   - opcode / funct values recognised by the controller
//   - FSM state encodings (plain localparams so legacy tools can read them)
//   - opcode class enum produced by opcode_classify
//   - alu_op, pc_source, reg_dst and mem_to_reg encodings
//   - ialu_op(): alu_op selection for immediate ALU instructions
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_EXEC_R   = 4'd6;
  localparam logic [3:0] ST_EXEC_I   = 4'd7;
  localparam logic [3:0] ST_ALU_WB   = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [3:0] ST_FAULT    = 4'd11;
  localparam logic [3:0] ST_JR_WB    = 4'd12;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic [2:0] ialu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: ialu_op = ALU_AND;
      OP_ORI:  ialu_op = ALU_OR;
      OP_SLTI: ialu_op = ALU_SLT;
      default: ialu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_classify.sv
// opcode_classify: combinational decode of the opcode field.
// Ports:
//   op_code   in  OPCODE_W  instruction opcode (IR[31:26])
//   op_class  out           instruction class (RTYPE/IALU/LOAD/STORE/BRANCH/JUMP/ILLEGAL)
//   link      out  1        jal: jump also writes the return address
//   branch_ne out  1        bne: branch taken on zero=0 instead of zero=1
module opcode_classify
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op_code,
  output op_class_t           op_class,
  output logic                link,
  output logic                branch_ne
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op_code)
      OPCODE_W'(OP_RTYPE):                     op_class = CLS_RTYPE;
      OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
      OPCODE_W'(OP_ORI),  OPCODE_W'(OP_SLTI):  op_class = CLS_IALU;
      OPCODE_W'(OP_LW):                        op_class = CLS_LOAD;
      OPCODE_W'(OP_SW):                        op_class = CLS_STORE;
      OPCODE_W'(OP_BEQ),  OPCODE_W'(OP_BNE):   op_class = CLS_BRANCH;
      OPCODE_W'(OP_J),    OPCODE_W'(OP_JAL):   op_class = CLS_JUMP;
      default:                                 op_class = CLS_ILLEGAL;
    endcase
  end

  assign link      = (op_code == OPCODE_W'(OP_JAL));
  assign branch_ne = (op_code == OPCODE_W'(OP_BNE));

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM driving a shared-memory datapath.
// Sequences fetch/decode/execute/memory/write-back, stalls on mem_ready,
// faults on illegal opcodes or bus timeout, and counts retired instructions.
// Optional feature macro: MULTICYCLE_CTRL_JR_EN (jr gets its own JR_WB state
// that loads the PC from rs; without it jr behaves as an ordinary R-type).
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   op_code, funct        IR opcode and funct fields
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory completes the current access this cycle
//   mem_read, mem_write   memory request strobes, held until mem_ready
//   i_or_d                memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write    IR load / unconditional PC load
//   pc_source             next-PC select
//   reg_dst, mem_to_reg   register-file write address / data select
//   reg_write             register-file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation
//   fault                 sticky fault flag (registered)
//   retired               retired-instruction count (registered, wraps)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int TIMEOUT  = 255,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_inc;
  logic             in_wait;
  logic             timed_out;
  logic             retire;
  logic             is_jr;
  op_class_t        op_class;
  logic             link;
  logic             branch_ne;

  opcode_classify #(
    .OPCODE_W (OPCODE_W)
  ) u_classify (
    .op_code   (op_code),
    .op_class  (op_class),
    .link      (link),
    .branch_ne (branch_ne)
  );

  assign is_jr = (op_class == CLS_RTYPE) && (funct == FUNCT_W'(FUNCT_JR));

`ifndef MULTICYCLE_CTRL_JR_EN
  logic jr_unused;
  assign jr_unused = is_jr;
`endif

  // A wait cycle is one spent in a memory-access state without mem_ready.
  // wait_inc counts the current cycle too, so the fault edge follows the
  // TIMEOUT-th consecutive wait cycle; mem_ready always takes priority.
  assign in_wait   = ((state == ST_FETCH) || (state == ST_MEM_RD) ||
                      (state == ST_MEM_WR)) && !mem_ready;
  assign wait_inc  = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
  assign timed_out = in_wait && (wait_inc >= (CNT_W + 1)'(TIMEOUT));

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready)      state_nx = ST_DECODE;
        else if (timed_out) state_nx = ST_FAULT;
      end
      ST_DECODE: begin
        case (op_class)
          CLS_RTYPE:             state_nx = ST_EXEC_R;
          CLS_IALU:              state_nx = ST_EXEC_I;
          CLS_LOAD, CLS_STORE:   state_nx = ST_MEM_ADDR;
          CLS_BRANCH:            state_nx = ST_BRANCH;
          CLS_JUMP:              state_nx = ST_JUMP;
          default:               state_nx = ST_FAULT;
        endcase
      end
      ST_MEM_ADDR: state_nx = (op_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_ready)      state_nx = ST_MEM_WB;
        else if (timed_out) state_nx = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (mem_ready)      state_nx = ST_FETCH;
        else if (timed_out) state_nx = ST_FAULT;
      end
`ifdef MULTICYCLE_CTRL_JR_EN
      ST_EXEC_R:   state_nx = is_jr ? ST_JR_WB : ST_ALU_WB;
      ST_JR_WB:    state_nx = ST_FETCH;
`else
      ST_EXEC_R:   state_nx = ST_ALU_WB;
`endif
      ST_EXEC_I:   state_nx = ST_ALU_WB;
      ST_ALU_WB,
      ST_MEM_WB,
      ST_BRANCH,
      ST_JUMP:     state_nx = ST_FETCH;
      ST_FAULT:    state_nx = ST_FAULT;
      default:     state_nx = ST_FAULT;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALUOUT;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    case (state)
      ST_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ialu_op(op_code[5:0]);
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_class == CLS_RTYPE) ? REGDST_RD : REGDST_RT;
        retire    = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = branch_ne ? !zero : zero;
        retire    = 1'b1;
      end
      ST_JUMP: begin
        // jal writes $31 in the same cycle the PC updates, so the register
        // file still sees the old PC (already PC+4) on the write-data mux.
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (link) begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
        end
      end
`ifdef MULTICYCLE_CTRL_JR_EN
      ST_JR_WB: begin
        pc_source = PCSRC_RS;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (in_wait && !timed_out) ? wait_inc[CNT_W-1:0] : '0;
      if (retire)
        retired <= retired + RETIRE_W'(1);
      if (state_nx == ST_FAULT)
        fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scenario tasks drive instructions cycle by cycle,
// push the expected control vector for each cycle onto a queue, capture the
// DUT's vector at the falling edge, then pop and compare both queues.
module tb_multicycle_control;

  typedef logic [18:0] vec_t;

  logic        clk;
  logic        reset;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        fault;
  logic [31:0] retired;

  int          checks;
  int          errors;
  logic [31:0] exp_ret;
  vec_t        exp_q[$];
  vec_t        act_q[$];

  multicycle_control #(
    .OPCODE_W (6),
    .FUNCT_W  (6),
    .TIMEOUT  (4),
    .RETIRE_W (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_code    (op_code),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timer expired");
    $fatal(1);
  end

  function automatic vec_t outs();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, fault};
  endfunction

  function automatic vec_t ev(input logic mr, input logic mw, input logic iod,
                              input logic irw, input logic pcw, input logic [1:0] pcs,
                              input logic [1:0] rd, input logic [1:0] m2r,
                              input logic rw, input logic asa, input logic [1:0] asb,
                              input logic [2:0] aop, input logic flt);
    return {mr, mw, iod, irw, pcw, pcs, rd, m2r, rw, asa, asb, aop, flt};
  endfunction

  // Expected control vectors per state, straight from the state descriptions.
  function automatic vec_t e_fetch(input logic r);
    return ev(1, 0, 0, r, r, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 3'b000, 0);
  endfunction
  function automatic vec_t e_decode();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 3'b000, 0);
  endfunction
  function automatic vec_t e_exec_r();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 3'b010, 0);
  endfunction
  function automatic vec_t e_exec_i(input logic [2:0] aop);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10, aop, 0);
  endfunction
  function automatic vec_t e_alu_wb(input logic [1:0] rd);
    return ev(0, 0, 0, 0, 0, 2'b00, rd, 2'b00, 1, 0, 2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_mem_addr();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 0);
  endfunction
  function automatic vec_t e_mem_rd();
    return ev(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_mem_wb();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_mem_wr();
    return ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_branch(input logic pcw);
    return ev(0, 0, 0, 0, pcw, 2'b01, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 0);
  endfunction
  function automatic vec_t e_jump(input logic l);
    return ev(0, 0, 0, 0, 1, 2'b10, l ? 2'b10 : 2'b00, l ? 2'b10 : 2'b00, l, 0,
              2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_jr_wb();
    return ev(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0);
  endfunction
  function automatic vec_t e_fault();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1);
  endfunction

  // One clock cycle: apply inputs, record expectation, capture DUT at negedge.
  task automatic cyc(input logic r, input logic z, input vec_t e);
    mem_ready = r;
    zero      = z;
    exp_q.push_back(e);
    @(negedge clk);
    act_q.push_back(outs());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_rtype();
    vec_t e, a;
    op_code = 6'h00; funct = 6'h20;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_exec_r());
    cyc(1, 0, e_alu_wb(2'b01));
    exp_ret = exp_ret + 1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL rtype cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL rtype_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_reset();
    vec_t a;
    do_reset();
    @(negedge clk);
    a = outs(); checks++;
    if (a !== e_fetch(0)) begin errors++; $display("FAIL reset_outputs got %h expected %h", a, e_fetch(0)); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d expected 0", retired); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b expected 0", fault); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ialu();
    vec_t e, a;
    logic [5:0] ops  [4];
    logic [2:0] aops [4];
    ops  = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
    aops = '{3'b000, 3'b011, 3'b100, 3'b101};
    for (int k = 0; k < 4; k++) begin
      op_code = ops[k]; funct = 6'h15;
      cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_exec_i(aops[k]));
      cyc(1, 0, e_alu_wb(2'b00));
      exp_ret = exp_ret + 1;
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL ialu cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL ialu_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_lw_wait();
    vec_t e, a;
    int irw_pulses;
    op_code = 6'h23; funct = 6'h00;
    repeat (3) cyc(0, 0, e_fetch(0));
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    repeat (2) cyc(0, 0, e_mem_rd());
    cyc(1, 0, e_mem_rd()); cyc(1, 0, e_mem_wb());
    exp_ret = exp_ret + 1;
    checks++;
    if (act_q.size() != 10) begin errors++; $display("FAIL lw_cycles got %0d expected 10", act_q.size()); end
    irw_pulses = 0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a[15]) irw_pulses++;
      if (a !== e) begin errors++; $display("FAIL lw_wait cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (irw_pulses != 1) begin errors++; $display("FAIL lw_ir_write_pulses got %0d expected 1", irw_pulses); end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL lw_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_sw();
    vec_t e, a;
    op_code = 6'h2B; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    cyc(1, 0, e_mem_wr());
    exp_ret = exp_ret + 1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL sw cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL sw_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_branch();
    vec_t e, a;
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       tk  [4];
    ops = '{6'h05, 6'h05, 6'h04, 6'h04};
    zs  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tk  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      op_code = ops[k]; funct = 6'h00;
      cyc(1, zs[k], e_fetch(1)); cyc(1, zs[k], e_decode()); cyc(1, zs[k], e_branch(tk[k]));
      exp_ret = exp_ret + 1;
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL branch cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL branch_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_jump();
    vec_t e, a;
    op_code = 6'h02; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_jump(0));
    op_code = 6'h03;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_jump(1));
    exp_ret = exp_ret + 2;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL jump cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL jump_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_jr();
    vec_t e, a;
    op_code = 6'h00; funct = 6'h08;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_exec_r());
`ifdef MULTICYCLE_CTRL_JR_EN
    cyc(1, 0, e_jr_wb());
`else
    cyc(1, 0, e_alu_wb(2'b01));
`endif
    exp_ret = exp_ret + 1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL jr cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL jr_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_reset_midwait();
    vec_t e, a;
    op_code = 6'h23; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    cyc(0, 0, e_mem_rd()); cyc(0, 0, e_mem_rd());
    reset = 1'b1;
    cyc(0, 0, e_mem_rd());
    reset = 1'b0;
    exp_ret = '0;
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL midwait_retired_cleared got %0d expected 0", retired); end
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    cyc(1, 0, e_mem_rd()); cyc(1, 0, e_mem_wb());
    exp_ret = exp_ret + 1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL midwait cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL midwait_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  // mem_ready on the TIMEOUT-th MEM_WR cycle completes the store normally.
  task automatic test_timeout_boundary();
    vec_t e, a;
    op_code = 6'h2B; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    repeat (3) cyc(0, 0, e_mem_wr());
    cyc(1, 0, e_mem_wr());
    cyc(0, 0, e_fetch(0));
    exp_ret = exp_ret + 1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL tmo_boundary cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL tmo_boundary_fault got %b expected 0", fault); end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL tmo_boundary_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_timeout();
    vec_t e, a;
    op_code = 6'h2B; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode()); cyc(1, 0, e_mem_addr());
    repeat (4) cyc(0, 0, e_mem_wr());
    cyc(0, 0, e_fault()); cyc(1, 0, e_fault()); cyc(1, 1, e_fault());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL timeout cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b expected 1", fault); end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL timeout_retired got %0d expected %0d", retired, exp_ret); end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL timeout_reset_clears got %b expected 0", fault); end
  endtask

  task automatic test_illegal();
    vec_t e, a;
    op_code = 6'h3F; funct = 6'h00;
    cyc(1, 0, e_fetch(1)); cyc(1, 0, e_decode());
    cyc(1, 0, e_fault()); cyc(0, 0, e_fault());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL illegal cycle %0d got %h expected %h", i, a, e); end
    end
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault got %b expected 1", fault); end
    checks++;
    if (retired !== exp_ret) begin errors++; $display("FAIL illegal_retired got %0d expected %0d", retired, exp_ret); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_ret   = '0;
    reset     = 1'b1;
    op_code   = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    do_reset();
    test_rtype();
    test_reset();
    test_ialu();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_jr();
    test_reset_midwait();
    test_timeout_boundary();
    test_timeout();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
